// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the RV32M/RV64M multi-cycle multiply/divide unit:
// funct3 opcodes, the EX result-select code and the sequencer states.
package ex_muldiv_pkg;

    localparam logic [2:0] EXE_MUL_OP    = 3'b000;
    localparam logic [2:0] EXE_MULH_OP   = 3'b001;
    localparam logic [2:0] EXE_MULHSU_OP = 3'b010;
    localparam logic [2:0] EXE_MULHU_OP  = 3'b011;
    localparam logic [2:0] EXE_DIV_OP    = 3'b100;
    localparam logic [2:0] EXE_DIVU_OP   = 3'b101;
    localparam logic [2:0] EXE_REM_OP    = 3'b110;
    localparam logic [2:0] EXE_REMU_OP   = 3'b111;

    // EX write-back mux select that routes result_o into the pipeline
    localparam logic [2:0] EXE_RES_MULDIV = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } muldiv_state_e;

    function automatic logic is_div_op(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic a_is_signed(input logic [2:0] op);
        return (op == EXE_MULH_OP) || (op == EXE_MULHSU_OP) ||
               (op == EXE_DIV_OP)  || (op == EXE_REM_OP);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] op);
        return (op == EXE_MULH_OP) || (op == EXE_DIV_OP) || (op == EXE_REM_OP);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ID/EX-side request and EX write-back response signals of the mul/div unit.
interface ex_muldiv_if #(parameter int XLEN = 32);

    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic [4:0]      wd_i;
    logic            annul_i;
    logic            stallreq_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      wd_o;

    modport master (
        output start_i, op_i, a_i, b_i, wd_i, annul_i,
        input  stallreq_o, valid_o, result_o, wd_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, wd_i, annul_i,
        output stallreq_o, valid_o, result_o, wd_o
    );

endinterface

// File: rtl/ex_muldiv_step.sv
// One combinational radix-2 step: shift-add multiply on {hi, multiplier} or
// restoring divide on {remainder, quotient}, both packed in a 2*XLEN accumulator.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_out
);

    logic [XLEN:0] sum;
    logic [XLEN:0] trial;
    logic [XLEN:0] diff;

    // The remainder stays below the divisor, so a borrow in diff means "restore"
    always_comb begin
        sum   = {1'b0, acc_in[2*XLEN-1:XLEN]} + {1'b0, operand};
        trial = acc_in[2*XLEN-1:XLEN-1];
        diff  = trial - {1'b0, operand};
        if (is_div) begin
            if (!diff[XLEN])
                acc_out = {diff[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
            else
                acc_out = {trial[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
        end else begin
            if (acc_in[0])
                acc_out = {sum, acc_in[XLEN-1:1]};
            else
                acc_out = {1'b0, acc_in[2*XLEN-1:XLEN], acc_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M/RV64M execute unit: iterates on operand magnitudes,
// applies signs in FIXUP and pulses a registered result for one cycle.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic        clk,
    input logic        rst,
    ex_muldiv_if.slave bus
);

    localparam int STEPS = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(STEPS - 1);
    localparam logic [XLEN-1:0]  MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e state_q, state_d;

    logic [2:0]        op_q;
    logic [4:0]        wd_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN-1:0]   operand_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_q;
    logic              rneg_q;
    logic [XLEN-1:0]   res_q;

    logic              accept;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, overflow, special;
    logic [XLEN-1:0]   special_res;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    logic [XLEN-1:0]   fix_res;

    assign accept = bus.start_i && !bus.annul_i;

    // Request decode: magnitudes, sign flags and the results that need no iteration
    always_comb begin
        a_neg       = a_is_signed(bus.op_i) && bus.a_i[XLEN-1];
        b_neg       = b_is_signed(bus.op_i) && bus.b_i[XLEN-1];
        mag_a       = a_neg ? (~bus.a_i + 1'b1) : bus.a_i;
        mag_b       = b_neg ? (~bus.b_i + 1'b1) : bus.b_i;
        div_zero    = is_div_op(bus.op_i) && (bus.b_i == '0);
        overflow    = ((bus.op_i == EXE_DIV_OP) || (bus.op_i == EXE_REM_OP)) &&
                      (bus.a_i == MIN_VAL) && (bus.b_i == '1);
        special     = div_zero || overflow;
        special_res = '0;
        if (div_zero)
            special_res = ((bus.op_i == EXE_DIV_OP) || (bus.op_i == EXE_DIVU_OP)) ? '1 : bus.a_i;
        else if (overflow)
            special_res = (bus.op_i == EXE_DIV_OP) ? MIN_VAL : '0;
    end

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : gen_step
        logic [2*XLEN-1:0] stage_in;
        logic [2*XLEN-1:0] stage_out;
        if (g == 0) begin : gen_first
            assign stage_in = acc_q;
        end else begin : gen_next
            assign stage_in = gen_step[g-1].stage_out;
        end
        muldiv_step #(.XLEN(XLEN)) u_step (
            .is_div  (op_q[2]),
            .acc_in  (stage_in),
            .operand (operand_q),
            .acc_out (stage_out)
        );
    end
    assign acc_next = gen_step[BITS_PER_CYCLE-1].stage_out;

    always_comb begin
        prod = neg_q ? (~acc_q + 1'b1) : acc_q;
        quo  = acc_q[XLEN-1:0];
        rem  = acc_q[2*XLEN-1:XLEN];
        case (op_q)
            EXE_MUL_OP:                             fix_res = prod[XLEN-1:0];
            EXE_MULH_OP, EXE_MULHSU_OP, EXE_MULHU_OP: fix_res = prod[2*XLEN-1:XLEN];
            EXE_DIV_OP, EXE_DIVU_OP:                fix_res = neg_q ? (~quo + 1'b1) : quo;
            default:                                fix_res = rneg_q ? (~rem + 1'b1) : rem;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Annul overrides every transition and withdraws the stall request at once
    always_comb begin
        state_d        = state_q;
        bus.stallreq_o = 1'b0;
        bus.valid_o    = 1'b0;
        bus.result_o   = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    bus.stallreq_o = 1'b1;
                    state_d        = special ? DONE : CALC;
                end
            end
            CALC: begin
                bus.stallreq_o = 1'b1;
                if (cnt_q == LAST) state_d = FIXUP;
            end
            FIXUP: begin
                bus.stallreq_o = 1'b1;
                state_d        = DONE;
            end
            DONE: begin
                bus.valid_o  = 1'b1;
                bus.result_o = res_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.annul_i) begin
            state_d        = IDLE;
            bus.stallreq_o = 1'b0;
        end
    end

    assign bus.wd_o = wd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= '0;
            wd_q      <= '0;
            acc_q     <= '0;
            operand_q <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            res_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q      <= bus.op_i;
                        wd_q      <= bus.wd_i;
                        acc_q     <= {{XLEN{1'b0}}, mag_a};
                        operand_q <= mag_b;
                        cnt_q     <= '0;
                        neg_q     <= a_neg ^ b_neg;
                        rneg_q    <= a_neg;
                        res_q     <= special_res;
                    end
                end
                CALC: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q + 1'b1;
                end
                FIXUP:   res_q <= fix_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: a 32-bit/1-bit-per-cycle and a
// 64-bit/4-bits-per-cycle instance checked against an arithmetic model.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    localparam int STEPS32 = 32;
    localparam int STEPS64 = 16;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  wd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    ex_muldiv_if #(.XLEN(32)) bus32 ();
    ex_muldiv_if #(.XLEN(64)) bus64 ();

    ex_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32.slave)
    );

    ex_muldiv #(.XLEN(64), .BITS_PER_CYCLE(4)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (bus64.slave)
    );

    always #5 clk = ~clk;

    int   testCount   = 0;
    int   failCount   = 0;
    int   validSeen32 = 0;
    int   validSeen64 = 0;
    exp_t q32[$];
    exp_t q64[$];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] widthMask(input bit wide);
        return wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] minValue(input bit wide);
        return wide ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    endfunction

    function automatic bit isSpecial(input bit wide, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] am, bm;
        am = a & widthMask(wide);
        bm = b & widthMask(wide);
        return (op[2] && bm == 64'd0) ||
               ((op == EXE_DIV_OP || op == EXE_REM_OP) && am == minValue(wide) && bm == widthMask(wide));
    endfunction

    // Reference arithmetic on sign/zero-extended operands
    function automatic logic [63:0] refModel(input bit wide, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0]  mask, am, bm, r;
        logic [127:0] as_, bs, au, bu, p;
        longint       sa, sb;
        bit           ovf;
        int           xl;
        xl   = wide ? 64 : 32;
        mask = widthMask(wide);
        am   = a & mask;
        bm   = b & mask;
        au   = {64'd0, am};
        bu   = {64'd0, bm};
        as_  = wide ? {{64{am[63]}}, am} : {{96{am[31]}}, am[31:0]};
        bs   = wide ? {{64{bm[63]}}, bm} : {{96{bm[31]}}, bm[31:0]};
        sa   = longint'(as_[63:0]);
        sb   = longint'(bs[63:0]);
        ovf  = (am == minValue(wide)) && (bm == mask);
        r    = 64'd0;
        case (op)
            EXE_MUL_OP:    begin p = au * bu;  r = p[63:0]; end
            EXE_MULH_OP:   begin p = as_ * bs; r = 64'(p >> xl); end
            EXE_MULHSU_OP: begin p = as_ * bu; r = 64'(p >> xl); end
            EXE_MULHU_OP:  begin p = au * bu;  r = 64'(p >> xl); end
            EXE_DIV_OP:    r = (bm == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : (ovf ? minValue(wide) : 64'(sa / sb));
            EXE_DIVU_OP:   r = (bm == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : am / bm;
            EXE_REM_OP:    r = (bm == 64'd0) ? am : (ovf ? 64'd0 : 64'(sa % sb));
            default:       r = (bm == 64'd0) ? am : am % bm;
        endcase
        return r & mask;
    endfunction

    task automatic drive(input bit wide, input logic s, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] wd, input logic an);
        if (wide) begin
            bus64.start_i = s;  bus64.op_i = op; bus64.a_i = a;
            bus64.b_i = b;      bus64.wd_i = wd; bus64.annul_i = an;
        end else begin
            bus32.start_i = s;  bus32.op_i = op; bus32.a_i = a[31:0];
            bus32.b_i = b[31:0]; bus32.wd_i = wd; bus32.annul_i = an;
        end
    endtask

    task automatic setStart(input bit wide, input logic s);
        if (wide) bus64.start_i = s;
        else      bus32.start_i = s;
    endtask

    task automatic setAnnul(input bit wide, input logic an);
        if (wide) bus64.annul_i = an;
        else      bus32.annul_i = an;
    endtask

    function automatic logic getStall(input bit wide);
        return wide ? bus64.stallreq_o : bus32.stallreq_o;
    endfunction

    function automatic logic getValid(input bit wide);
        return wide ? bus64.valid_o : bus32.valid_o;
    endfunction

    function automatic logic [63:0] getResult(input bit wide);
        return wide ? bus64.result_o : {32'd0, bus32.result_o};
    endfunction

    function automatic logic [4:0] getWd(input bit wide);
        return wide ? bus64.wd_o : bus32.wd_o;
    endfunction

    // Pushes the expected result, runs one op and checks its timing
    task automatic applyStimulus(input bit wide, input logic [2:0] op, input logic [63:0] a,
                                 input logic [63:0] b, input logic [4:0] wd);
        exp_t item;
        int   steps, cycles, stalls;
        bit   special, seen;
        steps    = wide ? STEPS64 : STEPS32;
        special  = isSpecial(wide, op, a, b);
        item.res = refModel(wide, op, a, b);
        item.wd  = wd;
        if (wide) q64.push_back(item);
        else      q32.push_back(item);
        @(negedge clk);
        drive(wide, 1'b1, op, a, b, wd, 1'b0);
        #1 checkOutput("stall_on_accept", 64'(getStall(wide)), 64'd1);
        @(posedge clk);
        #1 drive(wide, 1'b0, ~op, ~a, ~b, ~wd, 1'b0);
        cycles = 1;
        stalls = 0;
        seen   = 1'b0;
        while (cycles < 200) begin
            if (getValid(wide)) begin
                seen = 1'b1;
                break;
            end
            if (getStall(wide)) stalls++;
            @(posedge clk);
            #1 cycles++;
            setStart(wide, (cycles == 3) && !special);
        end
        setStart(wide, 1'b0);
        checkOutput("valid_seen", 64'(seen), 64'd1);
        checkOutput("latency", 64'(cycles), special ? 64'd1 : 64'(steps + 2));
        checkOutput("stall_cycles", 64'(stalls), special ? 64'd0 : 64'(steps + 1));
        @(posedge clk);
        #1;
        checkOutput("valid_one_cycle", 64'(getValid(wide)), 64'd0);
        checkOutput("result_zero_idle", getResult(wide), 64'd0);
    endtask

    always @(negedge clk) begin
        exp_t item32;
        if (!rst && bus32.valid_o) begin
            validSeen32++;
            if (q32.size() == 0) begin
                checkOutput("unexpected_valid32", 64'(bus32.valid_o), 64'd0);
            end else begin
                item32 = q32.pop_front();
                checkOutput("result32", {32'd0, bus32.result_o}, item32.res);
                checkOutput("wd32", 64'(bus32.wd_o), 64'(item32.wd));
            end
        end
    end

    always @(negedge clk) begin
        exp_t item64;
        if (!rst && bus64.valid_o) begin
            validSeen64++;
            if (q64.size() == 0) begin
                checkOutput("unexpected_valid64", 64'(bus64.valid_o), 64'd0);
            end else begin
                item64 = q64.pop_front();
                checkOutput("result64", bus64.result_o, item64.res);
                checkOutput("wd64", 64'(bus64.wd_o), 64'(item64.wd));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int vs;
        logic [2:0]  rop;
        logic [63:0] ra, rb;

        rst = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
        drive(1'b1, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            checkOutput("reset_valid", 64'(getValid(w != 0)), 64'd0);
            checkOutput("reset_result", getResult(w != 0), 64'd0);
            checkOutput("reset_wd", 64'(getWd(w != 0)), 64'd0);
            checkOutput("reset_stall", 64'(getStall(w != 0)), 64'd0);
        end
        @(negedge clk) rst = 1'b0;

        applyStimulus(1'b0, EXE_MUL_OP,    64'd7,          -64'sd3,        5'd1);
        applyStimulus(1'b0, EXE_MULH_OP,   64'h8000_0000,  64'h8000_0000,  5'd2);
        applyStimulus(1'b0, EXE_MULHU_OP,  64'h8000_0000,  64'h8000_0000,  5'd3);
        applyStimulus(1'b0, EXE_MULHSU_OP, 64'hFFFF_FFFF,  64'hFFFF_FFFF,  5'd4);
        applyStimulus(1'b0, EXE_DIV_OP,    -64'sd7,        64'd2,          5'd5);
        applyStimulus(1'b0, EXE_REM_OP,    -64'sd7,        64'd2,          5'd6);
        applyStimulus(1'b0, EXE_DIVU_OP,   64'hFFFF_FFFE,  64'd2,          5'd7);
        applyStimulus(1'b0, EXE_DIVU_OP,   64'd5,          64'd0,          5'd8);
        applyStimulus(1'b0, EXE_REM_OP,    64'd5,          64'd0,          5'd9);
        applyStimulus(1'b0, EXE_DIV_OP,    64'h8000_0000,  64'hFFFF_FFFF,  5'd10);
        applyStimulus(1'b0, EXE_REM_OP,    64'h8000_0000,  64'hFFFF_FFFF,  5'd11);
        applyStimulus(1'b0, EXE_DIV_OP,    64'd9,          64'd0,          5'd12);
        applyStimulus(1'b0, EXE_REMU_OP,   64'hDEAD_BEEF,  64'd0,          5'd13);
        applyStimulus(1'b0, EXE_REM_OP,    64'd7,          -64'sd2,        5'd14);

        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = {$urandom, $urandom};
            rb  = (i % 3 == 0) ? 64'($urandom_range(1, 5)) : {$urandom, $urandom};
            applyStimulus(1'b0, rop, ra, rb, 5'(i + 16));
        end

        // Annul mid-divide: no result may ever appear
        @(negedge clk);
        drive(1'b0, 1'b1, EXE_DIV_OP, 64'd100, 64'd7, 5'd30, 1'b0);
        @(posedge clk);
        #1 setStart(1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1 setAnnul(1'b0, 1'b1);
        #1 checkOutput("annul_stall_drop", 64'(getStall(1'b0)), 64'd0);
        @(posedge clk);
        #1 setAnnul(1'b0, 1'b0);
        #1;
        checkOutput("annul_valid_low", 64'(getValid(1'b0)), 64'd0);
        checkOutput("annul_idle_stall", 64'(getStall(1'b0)), 64'd0);
        vs = validSeen32;
        repeat (40) @(posedge clk);
        #1 checkOutput("annul_no_result", 64'(validSeen32), 64'(vs));

        // Start together with annul is not accepted
        @(negedge clk);
        drive(1'b0, 1'b1, EXE_MUL_OP, 64'd5, 64'd6, 5'd31, 1'b1);
        #1 checkOutput("start_annul_stall", 64'(getStall(1'b0)), 64'd0);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, EXE_MUL_OP, 64'd0, 64'd0, 5'd0, 1'b0);
        #1 checkOutput("start_annul_idle", 64'(getStall(1'b0)), 64'd0);
        repeat (40) @(posedge clk);
        #1 checkOutput("start_annul_no_result", 64'(validSeen32), 64'(vs));

        applyStimulus(1'b0, EXE_MUL_OP, 64'd3, 64'd4, 5'd12);

        applyStimulus(1'b1, EXE_DIVU_OP,   64'd1000000000000,      64'd7,                  5'd20);
        applyStimulus(1'b1, EXE_REMU_OP,   64'd1000000000000,      64'd7,                  5'd21);
        applyStimulus(1'b1, EXE_DIV_OP,    -64'sd1000000000000,    64'd7,                  5'd22);
        applyStimulus(1'b1, EXE_REM_OP,    -64'sd1000000000000,    64'd7,                  5'd23);
        applyStimulus(1'b1, EXE_MUL_OP,    64'h1_2345_6789,        64'hAB_CDEF,            5'd24);
        applyStimulus(1'b1, EXE_MULH_OP,   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd25);
        applyStimulus(1'b1, EXE_MULHSU_OP, -64'sd3,                64'hFFFF_FFFF_FFFF_FFFF, 5'd26);
        applyStimulus(1'b1, EXE_DIV_OP,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd27);
        applyStimulus(1'b1, EXE_DIVU_OP,   64'd42,                 64'd0,                  5'd28);
        for (int i = 0; i < 4; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            applyStimulus(1'b1, rop, ra, rb, 5'(i + 1));
        end

        // Reset in the middle of CALC clears every output at once
        @(negedge clk);
        drive(1'b1, 1'b1, EXE_DIVU_OP, 64'd1000000000000, 64'd7, 5'd19, 1'b0);
        @(posedge clk);
        #1 setStart(1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midcalc_reset_valid", 64'(getValid(1'b1)), 64'd0);
        checkOutput("midcalc_reset_result", getResult(1'b1), 64'd0);
        checkOutput("midcalc_reset_wd", 64'(getWd(1'b1)), 64'd0);
        checkOutput("midcalc_reset_stall", 64'(getStall(1'b1)), 64'd0);
        vs = validSeen64;
        @(negedge clk) rst = 1'b0;
        repeat (30) @(posedge clk);
        #1 checkOutput("midcalc_reset_no_result", 64'(validSeen64), 64'(vs));
        applyStimulus(1'b1, EXE_DIVU_OP, 64'd1000000000000, 64'd7, 5'd18);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard32_empty", 64'(q32.size()), 64'd0);
        checkOutput("scoreboard64_empty", 64'(q64.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
